// File: rtl/prog_sequencer.sv
// Program-download sequencer: holds the CPU in reset, clears instruction memory,
// streams loader words into memory and releases the CPU after a settle delay.
module prog_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  halt_req,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_clear,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  prog_enable,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done
);

  // Full memory depth expressed in the load_count width.
  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          SETTLE_LAST = 4'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    StHalt,
    StClear,
    StLoad,
    StFlush,
    StSettle,
    StRun
  } state_e;

  state_e              state_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] idx_q;
  logic [3:0]          settle_q;
  logic [ADDR_WIDTH:0] count_sat;
  logic                last_word;
  logic                accept;

  // Saturate the requested length and decode the accept / last-word conditions.
  always_comb begin
    count_sat = (load_count > DEPTH) ? DEPTH : load_count;
    accept    = in_valid && in_ready;
    last_word = (idx_q == (count_q - ONE));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHalt;
      count_q     <= '0;
      idx_q       <= '0;
      settle_q    <= '0;
      in_ready    <= 1'b0;
      mem_clear   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      prog_enable <= 1'b0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      mem_clear <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StHalt: begin
          if (load_start) begin
            state_q     <= StClear;
            count_q     <= count_sat;
            idx_q       <= '0;
            mem_clear   <= 1'b1;
            prog_enable <= 1'b1;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StClear: begin
          if (count_q == '0) begin
            state_q     <= StSettle;
            settle_q    <= '0;
            prog_enable <= 1'b0;
          end else begin
            state_q  <= StLoad;
            in_ready <= 1'b1;
          end
        end
        StLoad: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx_q[ADDR_WIDTH-1:0];
            mem_wdata <= in_data;
            idx_q     <= idx_q + ONE;
            if (last_word) begin
              in_ready <= 1'b0;
              state_q  <= StFlush;
            end
          end
        end
        StFlush: begin
          // Last write is on the bus this cycle; hand the address mux back next.
          prog_enable <= 1'b0;
          settle_q    <= '0;
          state_q     <= StSettle;
        end
        StSettle: begin
          settle_q <= settle_q + 4'd1;
          if (settle_q == SETTLE_LAST) begin
            state_q   <= StRun;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        StRun: begin
          // Reload takes priority over halt.
          if (load_start) begin
            state_q     <= StClear;
            count_q     <= count_sat;
            idx_q       <= '0;
            mem_clear   <= 1'b1;
            prog_enable <= 1'b1;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
          end else if (halt_req) begin
            state_q   <= StHalt;
            cpu_reset <= 1'b1;
          end
        end
        default: begin
          state_q   <= StHalt;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer.
module tb_prog_sequencer;

  logic       clk;
  logic       reset_n;
  logic       load_start;
  logic [4:0] load_count;
  logic       halt_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_clear;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       prog_enable;
  logic       cpu_reset;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  // Control outputs packed as {cpu_reset, prog_enable, mem_clear, mem_we, in_ready, busy, done}.
  logic [6:0] ctl;
  assign ctl = {cpu_reset, prog_enable, mem_clear, mem_we, in_ready, busy, done};

  logic [7:0] words1 [3] = '{8'h3B, 8'h2F, 8'h8E};
  logic [7:0] words2 [4] = '{8'h11, 8'hC4, 8'h5A, 8'hE7};
  logic       pat2   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  prog_sequencer #(
    .ADDR_WIDTH   (4),
    .DATA_WIDTH   (8),
    .RELEASE_DELAY(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_count (load_count),
    .halt_req   (halt_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_clear  (mem_clear),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .prog_enable(prog_enable),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_start = 1'b0; load_count = '0; halt_req = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #12;
    tests_run++;
    if (ctl !== 7'b1000000 || mem_addr !== 4'd0 || mem_wdata !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_values ctl=%b addr=%h data=%h exp ctl=1000000 addr=0 data=0",
               ctl, mem_addr, mem_wdata);
    end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (ctl !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_idle ctl=%b exp=1000000", ctl);
    end
  endtask

  task automatic test_basic_load();
    logic [6:0] exp;
    load_start = 1'b1; load_count = 5'd3;
    tick();
    load_start = 1'b0;
    tests_run++;
    if (ctl !== 7'b1110010) begin
      tests_failed++;
      $display("FAIL basic_clear ctl=%b exp=1110010", ctl);
    end
    in_valid = 1'b1; in_data = words1[0];
    tick();
    tests_run++;
    if (ctl !== 7'b1100110) begin
      tests_failed++;
      $display("FAIL basic_load_entry ctl=%b exp=1100110", ctl);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = (i < 2) ? 7'b1101110 : 7'b1101010;
      tests_run++;
      if (ctl !== exp || mem_addr !== 4'(i) || mem_wdata !== words1[i]) begin
        tests_failed++;
        $display("FAIL basic_write%0d ctl=%b addr=%h data=%h exp ctl=%b addr=%h data=%h",
                 i, ctl, mem_addr, mem_wdata, exp, 4'(i), words1[i]);
      end
      if (i < 2) in_data = words1[i+1];
      else       in_valid = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (ctl !== 7'b1000010) begin
        tests_failed++;
        $display("FAIL basic_settle%0d ctl=%b exp=1000010", i, ctl);
      end
    end
    tick();
    tests_run++;
    if (ctl !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL basic_run_entry ctl=%b exp=0000001", ctl);
    end
    tick();
    tests_run++;
    if (ctl !== 7'b0000000) begin
      tests_failed++;
      $display("FAIL basic_done_once ctl=%b exp=0000000", ctl);
    end
  endtask

  task automatic test_gapped_load();
    int         widx;
    logic [6:0] exp;
    widx = 0;
    load_start = 1'b1; load_count = 5'd4;
    tick();
    load_start = 1'b0;
    tests_run++;
    if (ctl !== 7'b1110010) begin
      tests_failed++;
      $display("FAIL gap_reload_clear ctl=%b exp=1110010", ctl);
    end
    tick();
    for (int k = 0; k < 7; k++) begin
      in_valid = pat2[k];
      in_data  = pat2[k] ? words2[widx] : 8'hFF;
      tick();
      if (pat2[k]) begin
        exp = (widx == 3) ? 7'b1101010 : 7'b1101110;
        tests_run++;
        if (ctl !== exp || mem_addr !== 4'(widx) || mem_wdata !== words2[widx]) begin
          tests_failed++;
          $display("FAIL gap_write%0d ctl=%b addr=%h data=%h exp ctl=%b addr=%h data=%h",
                   widx, ctl, mem_addr, mem_wdata, exp, 4'(widx), words2[widx]);
        end
        widx++;
      end else begin
        tests_run++;
        if (ctl !== 7'b1100110) begin
          tests_failed++;
          $display("FAIL gap_idle%0d ctl=%b exp=1100110", k, ctl);
        end
      end
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    tests_run++;
    if (ctl !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL gap_run_entry ctl=%b exp=0000001", ctl);
    end
  endtask

  task automatic test_zero_count();
    load_start = 1'b1; load_count = 5'd0;
    tick();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    tests_run++;
    if (ctl !== 7'b1110010) begin
      tests_failed++;
      $display("FAIL zero_clear ctl=%b exp=1110010", ctl);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (ctl !== 7'b1000010) begin
        tests_failed++;
        $display("FAIL zero_settle%0d ctl=%b exp=1000010", i, ctl);
      end
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (ctl !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL zero_run_entry ctl=%b exp=0000001", ctl);
    end
  endtask

  task automatic test_saturate();
    logic [6:0] exp;
    load_start = 1'b1; load_count = 5'd20;
    tick();
    load_start = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'hA0 + 8'(i);
      tick();
      exp = (i < 15) ? 7'b1101110 : 7'b1101010;
      tests_run++;
      if (ctl !== exp || mem_addr !== 4'(i) || mem_wdata !== 8'hA0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL sat_write%0d ctl=%b addr=%h data=%h exp ctl=%b addr=%h data=%h",
                 i, ctl, mem_addr, mem_wdata, exp, 4'(i), 8'hA0 + 8'(i));
      end
    end
    in_data = 8'hEE;
    tick();
    tests_run++;
    if (ctl !== 7'b1000010) begin
      tests_failed++;
      $display("FAIL sat_no_17th ctl=%b exp=1000010", ctl);
    end
    in_valid = 1'b0;
    tick(); tick();
    tests_run++;
    if (ctl !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL sat_run_entry ctl=%b exp=0000001", ctl);
    end
  endtask

  task automatic test_priority_halt();
    load_start = 1'b1; halt_req = 1'b1; load_count = 5'd0;
    tick();
    load_start = 1'b0; halt_req = 1'b0;
    tests_run++;
    if (ctl !== 7'b1110010) begin
      tests_failed++;
      $display("FAIL prio_reload_wins ctl=%b exp=1110010", ctl);
    end
    tick(); tick(); tick();
    tests_run++;
    if (ctl !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL prio_run_entry ctl=%b exp=0000001", ctl);
    end
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tests_run++;
    if (ctl !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL halt_entry ctl=%b exp=1000000", ctl);
    end
    tick(); tick();
    tests_run++;
    if (ctl !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL halt_hold ctl=%b exp=1000000", ctl);
    end
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1; load_count = 5'd5;
    tick();
    load_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    tick();
    in_data = 8'h02;
    tick();
    tests_run++;
    if (ctl !== 7'b1101110 || mem_addr !== 4'd1 || mem_wdata !== 8'h02) begin
      tests_failed++;
      $display("FAIL midload_write1 ctl=%b addr=%h data=%h exp ctl=1101110 addr=1 data=02",
               ctl, mem_addr, mem_wdata);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (ctl !== 7'b1000000 || mem_addr !== 4'd0 || mem_wdata !== 8'd0) begin
      tests_failed++;
      $display("FAIL midload_async ctl=%b addr=%h data=%h exp ctl=1000000 addr=0 data=0",
               ctl, mem_addr, mem_wdata);
    end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (ctl !== 7'b1000000) begin
        tests_failed++;
        $display("FAIL midload_halt%0d ctl=%b exp=1000000", i, ctl);
      end
    end
    in_valid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests_run++;
    if (ctl !== 7'b1110010) begin
      tests_failed++;
      $display("FAIL midload_restart ctl=%b exp=1110010", ctl);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_zero_count();
    test_saturate();
    test_priority_halt();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
